// File: rtl/ssem_pkg.sv
// Shared SSEM datapath types: arithmetic modes, serial FSM states, word width.
package ssem_pkg;

  localparam int unsigned SSEM_WORD = 32;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'd0,
    MODE_SUB  = 2'd1,
    MODE_NEG  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // SUB and NEG both add the inverted B operand with a carry-in of one.
  function automatic logic mode_inverts_b(mode_t m);
    return (m == MODE_SUB) || (m == MODE_NEG);
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Request/result bundle between a controller and the bit-serial adder.
interface serial_addsub_if #(
  parameter int unsigned WIDTH = ssem_pkg::SSEM_WORD
);

  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             sum_bit;
  logic             sum_valid;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, mode, a, b,
    input  busy, sum_bit, sum_valid, done, result, carry_out, overflow
  );

  modport slave (
    input  start, mode, a, b,
    output busy, sum_bit, sum_valid, done, result, carry_out, overflow
  );

endinterface

// File: rtl/serial_addsub_fa.sv
// Single-bit full-adder slice shared by every bit position of the serial adder.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Plain sum/majority-carry equations.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial LSB-first adder/subtractor: one full-adder slice plus a carry flop,
// one bit per clock, WIDTH run cycles followed by a one-cycle done.
module serial_addsub
  import ssem_pkg::*;
#(
  parameter int unsigned WIDTH = SSEM_WORD
) (
  input logic             clk,
  input logic             rst_n,
  serial_addsub_if.slave  bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   result;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic               busy;
  logic               done;
  logic               carry_out;
  logic               overflow;
  logic               fa_sum;
  logic               fa_cout;
  mode_t              req_mode;

  assign req_mode = mode_t'(bus.mode);

  full_adder_bit u_fa (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Control FSM, operand shifters, bit counter and result/flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_a      <= '0;
      op_b      <= '0;
      result    <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            // Mode only shapes the loaded operands, so later mode changes are inert.
            op_a  <= (req_mode == MODE_NEG) ? '0 : bus.a;
            op_b  <= mode_inverts_b(req_mode) ? ~bus.b : bus.b;
            carry <= mode_inverts_b(req_mode);
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          op_a   <= op_a >> 1;
          op_b   <= op_b >> 1;
          carry  <= fa_cout;
          result <= {fa_sum, result[WIDTH-1:1]};
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            // Carry flop still holds the carry into the MSB on this cycle.
            carry_out <= fa_cout;
            overflow  <= carry ^ fa_cout;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= ST_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Serial stream is taken straight off the adder slice while running.
  assign bus.sum_bit   = busy & fa_sum;
  assign bus.sum_valid = busy;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.result    = result;
  assign bus.carry_out = carry_out;
  assign bus.overflow  = overflow;

endmodule
